// File: rtl/beef_pkg.sv
// rtl/beef_pkg.sv - operation and state encodings shared by cell_rmw and its bench
package beef_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_RIGHT = 3'd3,
    OP_LEFT  = 3'd4,
    OP_IN    = 3'd5,
    OP_OUT   = 3'd6,
    OP_CLR   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_IN_WAIT  = 2'd2,
    ST_OUT_WAIT = 2'd3
  } state_e;

endpackage

// File: rtl/cell_rmw.sv
// rtl/cell_rmw.sv - data-cell read-modify-write engine with pointer and byte I/O handshakes
// Optional CELL_ZERO_FLAG_EN: read the current cell while idle and report mem[ptr]==0.
module cell_rmw
  import beef_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [7:0]    op_arg,
  output logic          op_done,
  output logic [AW-1:0] ptr,
  output logic          cell_zero,
  output logic [AW-1:0] memReadAddress,
  output logic [AW-1:0] memWriteAddress,
  output logic          ReadMem,
  output logic          WriteMem,
  output logic [7:0]    memDataIn,
  input  logic [7:0]    memDataOut,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready
);

  state_e        state;
  op_e           cur_op;
  logic [7:0]    cur_arg;
  logic [AW-1:0] arg_ext;
  logic          exec_reads;

  assign arg_ext         = AW'(cur_arg);
  assign memReadAddress  = ptr;
  assign memWriteAddress = ptr;
  assign op_ready        = (state == ST_IDLE) && !reset;
  assign in_ready        = (state == ST_IN_WAIT) && !reset;
  assign exec_reads      = (state == ST_EXEC) &&
                           (cur_op == OP_ADD || cur_op == OP_SUB || cur_op == OP_OUT);

`ifdef CELL_ZERO_FLAG_EN
  assign ReadMem   = exec_reads || (state == ST_IDLE);
  assign cell_zero = (state == ST_IDLE) && (memDataOut == 8'd0);
`else
  assign ReadMem   = exec_reads;
  assign cell_zero = 1'b0;
`endif

  // Writes are suppressed while reset is high so an aborted operation leaves memory untouched.
  always_comb begin
    WriteMem  = 1'b0;
    memDataIn = 8'd0;
    if (!reset) begin
      case (state)
        ST_EXEC: begin
          case (cur_op)
            OP_ADD: begin
              WriteMem  = 1'b1;
              memDataIn = memDataOut + cur_arg;
            end
            OP_SUB: begin
              WriteMem  = 1'b1;
              memDataIn = memDataOut - cur_arg;
            end
            OP_CLR: WriteMem = 1'b1;
            default: ;
          endcase
        end
        ST_IN_WAIT: begin
          if (in_valid) begin
            WriteMem  = 1'b1;
            memDataIn = in_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_op    <= OP_NOP;
      cur_arg   <= 8'd0;
      ptr       <= '0;
      op_done   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
    end else begin
      op_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            cur_op  <= op_e'(op_code);
            cur_arg <= op_arg;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (cur_op)
            OP_IN:  state <= ST_IN_WAIT;
            OP_OUT: begin
              out_data  <= memDataOut;
              out_valid <= 1'b1;
              state     <= ST_OUT_WAIT;
            end
            default: begin
              if (cur_op == OP_RIGHT) ptr <= ptr + arg_ext;
              if (cur_op == OP_LEFT)  ptr <= ptr - arg_ext;
              op_done <= 1'b1;
              state   <= ST_IDLE;
            end
          endcase
        end
        ST_IN_WAIT: begin
          if (in_valid) begin
            op_done <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_done   <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_rmw.sv
// tb/tb_cell_rmw.sv - directed self-checking bench for cell_rmw with a behavioural data memory
module tb_cell_rmw;
  import beef_pkg::*;

  logic       clk = 1'b0;
  logic       reset, op_valid, op_ready, op_done, cell_zero;
  logic [2:0] op_code;
  logic [7:0] op_arg, ptr, memReadAddress, memWriteAddress;
  logic       ReadMem, WriteMem, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] memDataIn, memDataOut, in_data, out_data;

  logic [7:0] mem [256];
  logic       pre_en = 1'b0;
  logic [7:0] pre_addr = 8'd0, pre_data = 8'd0;
  int         wr_count = 0;
  int         n_cmp = 0, n_fail = 0;

  always #5 clk = ~clk;

  assign memDataOut = mem[memReadAddress];
  always @(posedge clk) begin
    if (WriteMem) begin
      mem[memWriteAddress] <= memDataIn;
      wr_count = wr_count + 1;
    end else if (pre_en) begin
      mem[pre_addr] <= pre_data;
    end
  end

  cell_rmw #(.AW(8)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_arg(op_arg), .op_done(op_done), .ptr(ptr),
    .cell_zero(cell_zero), .memReadAddress(memReadAddress),
    .memWriteAddress(memWriteAddress), .ReadMem(ReadMem), .WriteMem(WriteMem),
    .memDataIn(memDataIn), .memDataOut(memDataOut), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_en = 1'b0;
  endtask

  // Presents one op for a single edge; returns in EXEC.
  task automatic issue(input op_e code, input logic [7:0] arg);
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL issue_ready: op_ready=%b expected 1", op_ready);
    end
    op_valid = 1'b1; op_code = code; op_arg = arg;
    step();
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; op_code = 3'd0; op_arg = 8'd0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({ptr, op_done, out_valid, out_data, WriteMem, in_ready} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_state: ptr=%h done=%b ov=%b od=%h wm=%b ir=%b expected all 0",
               ptr, op_done, out_valid, out_data, WriteMem, in_ready);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (op_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle: op_ready=%b expected 1", op_ready);
    end
  endtask

  task automatic test_add_sub();
    preload(8'd0, 8'd254);
    issue(OP_ADD, 8'd3);
    n_cmp++;
    if ({WriteMem, ReadMem, memDataIn} !== {2'b11, 8'd1}) begin
      n_fail++; $display("FAIL add_exec: wm=%b rm=%b din=%h expected 1 1 01", WriteMem, ReadMem, memDataIn);
    end
    step();
    n_cmp++;
    if ({op_done, op_ready, mem[0]} !== {2'b11, 8'd1}) begin
      n_fail++; $display("FAIL add_done: done=%b rdy=%b mem0=%h expected 1 1 01", op_done, op_ready, mem[0]);
    end
    step();
    n_cmp++;
    if (op_done !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse: op_done=%b expected 0", op_done);
    end
    preload(8'd0, 8'd0);
    issue(OP_SUB, 8'd1);
    step();
    n_cmp++;
    if (mem[0] !== 8'd255) begin
      n_fail++; $display("FAIL sub_wrap: mem0=%h expected ff", mem[0]);
    end
    begin
      int w0 = wr_count;
      issue(OP_ADD, 8'd0);
      step();
      n_cmp++;
      if (wr_count !== w0 + 1 || mem[0] !== 8'd255 || op_done !== 1'b1) begin
        n_fail++; $display("FAIL add_zero: writes=%0d mem0=%h done=%b expected %0d ff 1", wr_count, mem[0], op_done, w0 + 1);
      end
    end
    issue(OP_CLR, 8'd9);
    step();
    n_cmp++;
    if (mem[0] !== 8'd0) begin
      n_fail++; $display("FAIL clr: mem0=%h expected 00", mem[0]);
    end
`ifdef CELL_ZERO_FLAG_EN
    step();
    n_cmp++;
    if (cell_zero !== 1'b1 || ReadMem !== 1'b1) begin
      n_fail++; $display("FAIL zero_set: cell_zero=%b rm=%b expected 1 1", cell_zero, ReadMem);
    end
    issue(OP_ADD, 8'd1);
    n_cmp++;
    if (cell_zero !== 1'b0) begin
      n_fail++; $display("FAIL zero_exec: cell_zero=%b expected 0", cell_zero);
    end
    step();
    n_cmp++;
    if (cell_zero !== 1'b0 || mem[0] !== 8'd1) begin
      n_fail++; $display("FAIL zero_clear: cell_zero=%b mem0=%h expected 0 01", cell_zero, mem[0]);
    end
`else
    step();
    n_cmp++;
    if (cell_zero !== 1'b0 || ReadMem !== 1'b0) begin
      n_fail++; $display("FAIL zero_off: cell_zero=%b rm=%b expected 0 0", cell_zero, ReadMem);
    end
`endif
  endtask

  task automatic test_pointer();
    int w0 = wr_count;
    issue(OP_LEFT, 8'd1);
    step();
    n_cmp++;
    if (ptr !== 8'd255 || memReadAddress !== 8'd255 || memWriteAddress !== 8'd255) begin
      n_fail++; $display("FAIL left_wrap: ptr=%h ra=%h wa=%h expected ff", ptr, memReadAddress, memWriteAddress);
    end
    issue(OP_RIGHT, 8'd2);
    step();
    n_cmp++;
    if (ptr !== 8'd1 || op_done !== 1'b1) begin
      n_fail++; $display("FAIL right_wrap: ptr=%h done=%b expected 01 1", ptr, op_done);
    end
    n_cmp++;
    if (wr_count !== w0) begin
      n_fail++; $display("FAIL ptr_nowrite: writes=%0d expected %0d", wr_count, w0);
    end
  endtask

  task automatic test_out();
    preload(8'd1, 8'h41);
    issue(OP_OUT, 8'd0);
    step();
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== 8'h41 || op_done !== 1'b0 || WriteMem !== 1'b0) begin
        n_fail++; $display("FAIL out_hold[%0d]: ov=%b od=%h done=%b wm=%b expected 1 41 0 0", i, out_valid, out_data, op_done, WriteMem);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || op_done !== 1'b1 || op_ready !== 1'b1) begin
      n_fail++; $display("FAIL out_handshake: ov=%b done=%b rdy=%b expected 0 1 1", out_valid, op_done, op_ready);
    end
  endtask

  task automatic test_in();
    issue(OP_IN, 8'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1 || WriteMem !== 1'b0 || op_ready !== 1'b0) begin
        n_fail++; $display("FAIL in_wait[%0d]: ir=%b wm=%b rdy=%b expected 1 0 0", i, in_ready, WriteMem, op_ready);
      end
      step();
    end
    in_valid = 1'b1; in_data = 8'h7F;
    #1;
    n_cmp++;
    if (WriteMem !== 1'b1 || memDataIn !== 8'h7F) begin
      n_fail++; $display("FAIL in_write: wm=%b din=%h expected 1 7f", WriteMem, memDataIn);
    end
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (mem[1] !== 8'h7F || in_ready !== 1'b0 || op_done !== 1'b1) begin
      n_fail++; $display("FAIL in_done: mem1=%h ir=%b done=%b expected 7f 0 1", mem[1], in_ready, op_done);
    end
  endtask

  task automatic test_reset_mid();
    int w0;
    issue(OP_IN, 8'd0);
    step();
    w0 = wr_count;
    in_valid = 1'b1; in_data = 8'h55; reset = 1'b1;
    #1;
    n_cmp++;
    if (WriteMem !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_comb: wm=%b ir=%b expected 0 0", WriteMem, in_ready);
    end
    step();
    in_valid = 1'b0; reset = 1'b0;
    n_cmp++;
    if (ptr !== 8'd0 || op_done !== 1'b0 || mem[1] !== 8'h7F || wr_count !== w0) begin
      n_fail++; $display("FAIL abort_state: ptr=%h done=%b mem1=%h writes=%0d expected 00 0 7f %0d", ptr, op_done, mem[1], wr_count, w0);
    end
    step();
    n_cmp++;
    if (op_ready !== 1'b1 || op_done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: rdy=%b done=%b ir=%b expected 1 0 0", op_ready, op_done, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    preload(8'd0, 8'd10);
    op_valid = 1'b1; op_code = OP_ADD; op_arg = 8'd1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (op_done === 1'b1) dones++;
    end
    op_valid = 1'b0;
    n_cmp++;
    if (dones !== 3 || mem[0] !== 8'd13) begin
      n_fail++; $display("FAIL back_to_back: dones=%0d mem0=%h expected 3 0d", dones, mem[0]);
    end
  endtask

  task automatic test_nop();
    int w0 = wr_count;
    int t = 0;
    issue(OP_NOP, 8'd5);
    while (op_done !== 1'b1 && t < 10) begin
      step();
      t++;
    end
    n_cmp++;
    if (t !== 1 || wr_count !== w0 || ptr !== 8'd0) begin
      n_fail++; $display("FAIL nop: cycles=%0d writes=%0d ptr=%h expected 1 %0d 00", t, wr_count, w0, ptr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    test_reset();
    test_add_sub();
    test_pointer();
    test_out();
    test_in();
    test_reset_mid();
    test_back_to_back();
    test_nop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
